window_scheduler: RTL and testbench
===================================

Name: window_scheduler

Overview:
- Sequences the window-position shift register: emits one-cycle shift pulses and the matching vertical position value.
- On game start, preloads all P_NUM slots with a centred position.
- While running, spawns one new position every SPAWN_FRAMES frame ticks. Each new position is a bounded pseudo-random step (LFSR) from the previous one, saturated to the playable range.
- Sits between game control (start/stop/pause, frame tick from VGA timing) and the window register chain.

Parameters:
- V_TOT, 525, vertical total lines; V_SIZE = $clog2(V_TOT) = 10 is the value width.
- P_NUM, 4, number of window slots to preload.
- SPAWN_FRAMES, 90, frame ticks between spawns; must be >= 1.
- GAP_MIN, 80, lowest legal position.
- GAP_MAX, 400, highest legal position; GAP_MIN <= GAP_INIT <= GAP_MAX < V_TOT.
- GAP_INIT, 240, preload value and first reference value.
- STEP_SHIFT, 3, left shift applied to the raw step.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- iClk  in  1  system clock
- iRst  in  1  asynchronous, active-high reset
- iStart  in  1  start pulse; honoured only in IDLE
- iStop  in  1  stop (collision or game over); forces IDLE from any state
- iPause  in  1  level; freezes frame counting in RUN
- iFrameTick  in  1  one-cycle pulse per frame
- oShift  out  1  one-cycle shift strobe to the window registers
- oValue  out  V_SIZE  position to shift in; valid when oShift=1, held otherwise
- oRunning  out  1  high in PRELOAD and RUN
- oSpawnCnt  out  8  spawns since start, saturating at 255

Behaviour:
- Reset (async, iRst=1): state=IDLE, oShift=0, oValue=GAP_INIT, oRunning=0, oSpawnCnt=0, frame counter=0, preload counter=0, LFSR=LFSR_SEED. Reset mid-operation aborts immediately; no partial shift is emitted.
- Registered outputs: every output is driven from registers, so oShift is high exactly one cycle per event.
- IDLE:
  - iStart=1 and iStop=0 -> PRELOAD. Also clear oSpawnCnt and the frame counter, and set oValue=GAP_INIT.
  - Do not reseed the LFSR.
- PRELOAD:
  - Assert oShift on P_NUM consecutive cycles with oValue=GAP_INIT. The first pulse is in the cycle after the start is accepted.
  - After the P_NUM-th pulse -> RUN.
  - iPause and iFrameTick are ignored in this state.
- RUN:
  - When iFrameTick=1 and iPause=0, increment the frame counter (width $clog2(SPAWN_FRAMES+1)).
  - On the tick that makes the count equal SPAWN_FRAMES: in the next cycle assert oShift with the new oValue, reset the counter to 0, advance the LFSR once, and increment oSpawnCnt (saturating).
  - iPause=1 holds the counter unchanged; the pause state is not latched.
- Stop precedence: iStop=1 in any state -> IDLE next cycle with oShift=0. If a spawn would occur the same cycle, the stop wins and no shift is emitted. The counter clears, oValue holds, and oSpawnCnt holds.
- iStart in PRELOAD or RUN: ignored.
- LFSR: 16-bit Fibonacci.
  - fb = l[15]^l[13]^l[12]^l[10]
  - next = {l[14:0], fb}
  - Advances only on spawn.
- New value: computed from the advanced LFSR, nl.
  - raw = nl[3:0], range 0..15.
  - step = (raw - 8) << STEP_SHIFT, signed, range -64..+56 at the default STEP_SHIFT.
  - sum = oValue + step, evaluated signed in V_SIZE+2 bits.
  - Saturate: below GAP_MIN -> GAP_MIN; above GAP_MAX -> GAP_MAX.
- FSM state encoding: IDLE=0, PRELOAD=1, RUN=2; the value 3 recovers to IDLE.

Decomposition:
- Shared package (window_pkg): V_TOT, P_NUM, V_SIZE, GAP_MIN/GAP_MAX/GAP_INIT, the state encoding constants, and the LFSR tap definition. The same constants are used by the window register chain and the renderer.
- Sub-module lfsr16 (iClk, iRst, iAdvance, oState; parameter SEED): natural and reusable elsewhere in the game.
- Step/saturation logic stays in the scheduler as combinational logic.

Test Plan:
- Reset then iStart pulse at cycle 10 -> oShift high on cycles 11-14 with oValue=240 on each, oRunning=1 from cycle 11, RUN from cycle 15.
- RUN with 90 iFrameTick pulses (iPause=0) -> exactly one oShift, one cycle after the 90th tick. LFSR=16'h59C3, raw=3, step=-40, oValue=200, oSpawnCnt=1.
- iPause=1 across 30 of the ticks -> spawn delayed by exactly 30 ticks; the count resumes from its held value.
- Force oValue=90 with a step of -64 (raw=0) -> oValue saturates to 80. oValue=390 with a step of +56 -> oValue saturates to 400.
- iStop coinciding with the spawn-triggering tick -> no oShift, IDLE next cycle, oSpawnCnt unchanged. A subsequent iStart restarts the preload with 240 × 4.
- iRst asserted asynchronously mid-PRELOAD (after the 2nd pulse) -> all outputs return to reset values immediately, with no further shifts.

Source files
------------

// File: rtl/window_pkg.sv
// Shared constants for the window scheduler, register chain and renderer.
// Also holds the FSM state encoding and the LFSR tap set.
package window_pkg;

  localparam int V_TOT        = 525;
  localparam int V_SIZE       = $clog2(V_TOT);
  localparam int P_NUM        = 4;
  localparam int SPAWN_FRAMES = 90;
  localparam int GAP_MIN      = 80;
  localparam int GAP_MAX      = 400;
  localparam int GAP_INIT     = 240;
  localparam int STEP_SHIFT   = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    RUN     = 2'd2
  } stateE;

  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when iAdvance is high.
module lfsr16 #(
  parameter logic [15:0] SEED = window_pkg::LFSR_SEED
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iAdvance,
  output logic [15:0] oState
);
  import window_pkg::*;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oState <= SEED;
    end else if (iAdvance) begin
      oState <= lfsrNext(oState);
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Window spawn sequencer: preloads P_NUM centred slots on start, then emits a
// randomly stepped, range-limited position every SPAWN_FRAMES frame ticks.
//
// state   | meaning
// IDLE    | waiting for start, outputs held
// PRELOAD | shifting GAP_INIT into every slot, one per cycle
// RUN     | counting unpaused frame ticks, spawning on terminal count
module window_scheduler #(
  parameter int V_TOT        = window_pkg::V_TOT,
  parameter int P_NUM        = window_pkg::P_NUM,
  parameter int SPAWN_FRAMES = window_pkg::SPAWN_FRAMES,
  parameter int GAP_MIN      = window_pkg::GAP_MIN,
  parameter int GAP_MAX      = window_pkg::GAP_MAX,
  parameter int GAP_INIT     = window_pkg::GAP_INIT,
  parameter int STEP_SHIFT   = window_pkg::STEP_SHIFT,
  parameter logic [15:0] LFSR_SEED = window_pkg::LFSR_SEED,
  localparam int V_SIZE      = $clog2(V_TOT)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iStop,
  input  logic              iPause,
  input  logic              iFrameTick,
  output logic              oShift,
  output logic [V_SIZE-1:0] oValue,
  output logic              oRunning,
  output logic [7:0]        oSpawnCnt
);
  import window_pkg::*;

  localparam int FC_W = $clog2(SPAWN_FRAMES + 1);
  localparam int PC_W = $clog2(P_NUM + 1);
  localparam int SW   = V_SIZE + 2;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(SPAWN_FRAMES - 1);
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(P_NUM);
  localparam logic [V_SIZE-1:0] VAL_INIT = V_SIZE'(GAP_INIT);
  localparam logic [V_SIZE-1:0] VAL_MIN  = V_SIZE'(GAP_MIN);
  localparam logic [V_SIZE-1:0] VAL_MAX  = V_SIZE'(GAP_MAX);
  localparam logic signed [SW-1:0] SUM_MIN   = SW'(GAP_MIN);
  localparam logic signed [SW-1:0] SUM_MAX   = SW'(GAP_MAX);
  localparam logic signed [SW-1:0] STEP_BIAS = SW'(8);

  stateE             state, nextState;
  logic [FC_W-1:0]   frameCnt, frameCntD;
  logic [PC_W-1:0]   preCnt, preCntD;
  logic              shiftD, runningD;
  logic [V_SIZE-1:0] valueD, newValue;
  logic [7:0]        spawnCntD;
  logic [15:0]       lfsrState;
  logic              tickValid, spawn, advance;

  assign tickValid = iFrameTick && !iPause;
  assign spawn     = (state == RUN) && tickValid && (frameCnt == FC_LAST);
  assign advance   = spawn && !iStop;

  lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
    .iClk     (iClk),
    .iRst     (iRst),
    .iAdvance (advance),
    .oState   (lfsrState)
  );

  // Low nibble of the advanced LFSR, built directly from the current state.
  always_comb begin
    logic [3:0] raw;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    raw  = {lfsrState[2:0], ^(lfsrState & LFSR_TAPS)};
    step = $signed({{(SW-4){1'b0}}, raw}) - STEP_BIAS;
    step = step <<< STEP_SHIFT;
    sum  = $signed({2'b00, oValue}) + step;
    if (sum < SUM_MIN) begin
      newValue = VAL_MIN;
    end else if (sum > SUM_MAX) begin
      newValue = VAL_MAX;
    end else begin
      newValue = sum[V_SIZE-1:0];
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = PRELOAD;
      PRELOAD: if (preCnt == PC_LAST) nextState = RUN;
      RUN:     nextState = RUN;
      default: nextState = IDLE;
    endcase
    if (iStop) nextState = IDLE;
  end

  always_comb begin
    shiftD    = 1'b0;
    valueD    = oValue;
    frameCntD = frameCnt;
    preCntD   = preCnt;
    spawnCntD = oSpawnCnt;
    case (state)
      IDLE: begin
        if (iStart) begin
          shiftD    = 1'b1;
          valueD    = VAL_INIT;
          preCntD   = PC_W'(1);
          frameCntD = '0;
          spawnCntD = '0;
        end
      end
      PRELOAD: begin
        if (preCnt != PC_LAST) begin
          shiftD  = 1'b1;
          preCntD = preCnt + PC_W'(1);
        end else begin
          preCntD = '0;
        end
      end
      RUN: begin
        if (spawn) begin
          shiftD    = 1'b1;
          valueD    = newValue;
          frameCntD = '0;
          if (oSpawnCnt != 8'hFF) spawnCntD = oSpawnCnt + 8'd1;
        end else if (tickValid) begin
          frameCntD = frameCnt + FC_W'(1);
        end
      end
      default: ;
    endcase
    // Stop beats everything, including a spawn in the same cycle.
    if (iStop) begin
      shiftD    = 1'b0;
      valueD    = oValue;
      frameCntD = '0;
      preCntD   = '0;
      spawnCntD = oSpawnCnt;
    end
    runningD = (nextState == PRELOAD) || (nextState == RUN);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oShift    <= 1'b0;
      oValue    <= VAL_INIT;
      oRunning  <= 1'b0;
      oSpawnCnt <= '0;
      frameCnt  <= '0;
      preCnt    <= '0;
    end else begin
      oShift    <= shiftD;
      oValue    <= valueD;
      oRunning  <= runningD;
      oSpawnCnt <= spawnCntD;
      frameCnt  <= frameCntD;
      preCnt    <= preCntD;
    end
  end

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler; two extra instances with edge-case
// initial values and seeds exercise range saturation and counter saturation.
module tb_window_scheduler;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iStart = 1'b0;
  logic       iStop = 1'b0;
  logic       iPause = 1'b0;
  logic       iFrameTick = 1'b0;
  logic       oShift, oRunning;
  logic [9:0] oValue;
  logic [7:0] oSpawnCnt;
  logic       loShift, loRunning, hiShift, hiRunning;
  logic [9:0] loValue, hiValue;
  logic [7:0] loSpawnCnt, hiSpawnCnt;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  window_scheduler dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStop(iStop), .iPause(iPause),
    .iFrameTick(iFrameTick), .oShift(oShift), .oValue(oValue),
    .oRunning(oRunning), .oSpawnCnt(oSpawnCnt)
  );

  // Seed 0x0008 advances to 0x0010 (raw 0, step -64): 90-64 saturates to 80.
  window_scheduler #(.SPAWN_FRAMES(1), .GAP_INIT(90), .LFSR_SEED(16'h0008)) satLo (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStop(iStop), .iPause(iPause),
    .iFrameTick(iFrameTick), .oShift(loShift), .oValue(loValue),
    .oRunning(loRunning), .oSpawnCnt(loSpawnCnt)
  );

  // Seed 0x8007 advances to 0x000F (raw 15, step +56): 390+56 saturates to 400.
  window_scheduler #(.SPAWN_FRAMES(1), .GAP_INIT(390), .LFSR_SEED(16'h8007)) satHi (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStop(iStop), .iPause(iPause),
    .iFrameTick(iFrameTick), .oShift(hiShift), .oValue(hiValue),
    .oRunning(hiRunning), .oSpawnCnt(hiSpawnCnt)
  );

  task automatic stepCycle();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    stepCycle();
    iStart = 1'b0;
  endtask

  // Each tick is followed by one idle cycle; counts main-DUT shift strobes.
  task automatic doTicks(input int n, input logic paused, output int shifts);
    shifts = 0;
    iPause = paused;
    for (int i = 0; i < n; i++) begin
      iFrameTick = 1'b1;
      stepCycle();
      iFrameTick = 1'b0;
      if (oShift) shifts++;
      stepCycle();
      if (oShift) shifts++;
    end
    iPause = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (3) stepCycle();
    checks++; if (oShift !== 1'b0) begin errors++; $display("FAIL reset_shift: got %b expected 0", oShift); end
    checks++; if (oValue !== 10'd240) begin errors++; $display("FAIL reset_value: got %0d expected 240", oValue); end
    checks++; if (oRunning !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", oRunning); end
    checks++; if (oSpawnCnt !== 8'd0) begin errors++; $display("FAIL reset_spawncnt: got %0d expected 0", oSpawnCnt); end
    iRst = 1'b0;
    repeat (6) stepCycle();
  endtask

  task automatic test_preload();
    int shifts;
    doTicks(3, 1'b0, shifts);
    checks++; if (shifts !== 0) begin errors++; $display("FAIL idle_no_shift: got %0d expected 0", shifts); end
    pulseStart();
    for (int k = 0; k < 4; k++) begin
      checks++; if (oShift !== 1'b1 || oValue !== 10'd240 || oRunning !== 1'b1) begin
        errors++; $display("FAIL preload_pulse%0d: got shift=%b value=%0d running=%b expected 1/240/1", k, oShift, oValue, oRunning);
      end
      stepCycle();
    end
    checks++; if (oShift !== 1'b0 || oRunning !== 1'b1) begin
      errors++; $display("FAIL preload_end: got shift=%b running=%b expected 0/1", oShift, oRunning);
    end
  endtask

  task automatic test_spawn();
    int shifts;
    doTicks(89, 1'b0, shifts);
    checks++; if (shifts !== 0) begin errors++; $display("FAIL spawn_early: got %0d shifts expected 0", shifts); end
    iFrameTick = 1'b1;
    stepCycle();
    iFrameTick = 1'b0;
    checks++; if (oShift !== 1'b1 || oValue !== 10'd200 || oSpawnCnt !== 8'd1) begin
      errors++; $display("FAIL spawn_first: got shift=%b value=%0d cnt=%0d expected 1/200/1", oShift, oValue, oSpawnCnt);
    end
    stepCycle();
    checks++; if (oShift !== 1'b0 || oValue !== 10'd200) begin
      errors++; $display("FAIL spawn_one_cycle: got shift=%b value=%0d expected 0/200", oShift, oValue);
    end
  endtask

  task automatic test_pause();
    int s1, s2, s3;
    doTicks(60, 1'b0, s1);
    doTicks(30, 1'b1, s2);
    doTicks(29, 1'b0, s3);
    checks++; if (s1 + s2 + s3 !== 0) begin errors++; $display("FAIL pause_hold: got %0d shifts expected 0", s1 + s2 + s3); end
    iFrameTick = 1'b1;
    stepCycle();
    iFrameTick = 1'b0;
    checks++; if (oShift !== 1'b1 || oValue !== 10'd192 || oSpawnCnt !== 8'd2) begin
      errors++; $display("FAIL pause_spawn: got shift=%b value=%0d cnt=%0d expected 1/192/2", oShift, oValue, oSpawnCnt);
    end
    stepCycle();
  endtask

  task automatic test_stop_at_spawn();
    int shifts;
    doTicks(89, 1'b0, shifts);
    iFrameTick = 1'b1;
    iStop = 1'b1;
    stepCycle();
    iFrameTick = 1'b0;
    iStop = 1'b0;
    checks++; if (oShift !== 1'b0 || oRunning !== 1'b0 || oSpawnCnt !== 8'd2 || oValue !== 10'd192) begin
      errors++; $display("FAIL stop_wins: got shift=%b running=%b cnt=%0d value=%0d expected 0/0/2/192", oShift, oRunning, oSpawnCnt, oValue);
    end
    repeat (3) stepCycle();
    pulseStart();
    for (int k = 0; k < 4; k++) begin
      checks++; if (oShift !== 1'b1 || oValue !== 10'd240 || oSpawnCnt !== 8'd0) begin
        errors++; $display("FAIL restart_pulse%0d: got shift=%b value=%0d cnt=%0d expected 1/240/0", k, oShift, oValue, oSpawnCnt);
      end
      stepCycle();
    end
    // LFSR must still be 0xB387 (stopped spawn did not advance): next 0x670F, +56.
    doTicks(89, 1'b0, shifts);
    checks++; if (shifts !== 0) begin errors++; $display("FAIL restart_early: got %0d shifts expected 0", shifts); end
    iFrameTick = 1'b1;
    stepCycle();
    iFrameTick = 1'b0;
    checks++; if (oShift !== 1'b1 || oValue !== 10'd296 || oSpawnCnt !== 8'd1) begin
      errors++; $display("FAIL restart_spawn: got shift=%b value=%0d cnt=%0d expected 1/296/1", oShift, oValue, oSpawnCnt);
    end
    stepCycle();
  endtask

  task automatic test_start_ignored();
    pulseStart();
    checks++; if (oShift !== 1'b0 || oRunning !== 1'b1 || oSpawnCnt !== 8'd1) begin
      errors++; $display("FAIL start_in_run: got shift=%b running=%b cnt=%0d expected 0/1/1", oShift, oRunning, oSpawnCnt);
    end
  endtask

  task automatic test_reset_mid_preload();
    int shifts;
    iStop = 1'b1;
    stepCycle();
    iStop = 1'b0;
    stepCycle();
    pulseStart();
    stepCycle();
    #2 iRst = 1'b1;
    #1;
    checks++; if (oShift !== 1'b0 || oRunning !== 1'b0 || oValue !== 10'd240 || oSpawnCnt !== 8'd0) begin
      errors++; $display("FAIL async_reset: got shift=%b running=%b value=%0d cnt=%0d expected 0/0/240/0", oShift, oRunning, oValue, oSpawnCnt);
    end
    stepCycle();
    iRst = 1'b0;
    shifts = 0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      if (oShift) shifts++;
    end
    checks++; if (shifts !== 0 || oRunning !== 1'b0) begin
      errors++; $display("FAIL reset_no_resume: got shifts=%0d running=%b expected 0/0", shifts, oRunning);
    end
  endtask

  task automatic test_saturation();
    int shifts;
    pulseStart();
    repeat (4) stepCycle();
    iFrameTick = 1'b1;
    stepCycle();
    iFrameTick = 1'b0;
    checks++; if (loShift !== 1'b1 || loValue !== 10'd80) begin
      errors++; $display("FAIL sat_low: got shift=%b value=%0d expected 1/80", loShift, loValue);
    end
    checks++; if (hiShift !== 1'b1 || hiValue !== 10'd400) begin
      errors++; $display("FAIL sat_high: got shift=%b value=%0d expected 1/400", hiShift, hiValue);
    end
    stepCycle();
    doTicks(253, 1'b0, shifts);
    checks++; if (loSpawnCnt !== 8'd254) begin errors++; $display("FAIL spawncnt_254: got %0d expected 254", loSpawnCnt); end
    doTicks(3, 1'b0, shifts);
    checks++; if (loSpawnCnt !== 8'd255) begin errors++; $display("FAIL spawncnt_sat: got %0d expected 255", loSpawnCnt); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_spawn();
    test_pause();
    test_stop_at_spawn();
    test_start_ignored();
    test_reset_mid_preload();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
